ahb_csr_bridge: RTL and testbench
=================================

Name: ahb_csr_bridge

Overview:
- Parametrised AHB-Lite slave that bridges single-beat AHB transfers onto a simple CSR register bus.
- Generalised in address width, data width and address range.
- Adds features the first-generation bridge lacks:
  - zero-wait posted writes;
  - byte write strobes derived from HSIZE/HADDR;
  - variable-latency reads, completed by a csr_rvalid handshake;
  - a two-cycle AHB ERROR response for illegal accesses.
- Sits behind the AHB decoder, one instance per CSR bank.

Parameters:
- ADDR_WID, 12: width of csr_addr; the low ADDR_WID bits of HADDR are used.
- DATA_WID, 32: AHB/CSR data width. Legal values are 32 or 64.
- ADDR_RANGE, 4096: number of valid bytes. Any offset >= ADDR_RANGE is an error.
- TIMEOUT_CYCLES, 64: read timeout. Used only when AHB_CSR_TIMEOUT_EN is defined.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous reset, active-high
- HSEL  in  1  slave select
- HADDR  in  32  address
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HTRANS  in  2  transfer type
- HREADY  in  1  bus ready
- HWDATA  in  DATA_WID  write data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  DATA_WID  read data
- csr_addr  out  ADDR_WID  CSR byte address, aligned to DATA_WID
- csr_wren  out  1  one-cycle write pulse
- csr_wstrb  out  DATA_WID/8  byte strobes
- csr_wdata  out  DATA_WID  write data
- csr_rden  out  1  one-cycle read pulse
- csr_rdata  in  DATA_WID  read data
- csr_rvalid  in  1  csr_rdata valid; arrives >=1 cycle after csr_rden

Behaviour:
- Clock and reset: one clock (HCLK); HRESET is asynchronous, active-high.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0;
  - all csr_* outputs 0;
  - state=IDLE, no pending write.
- Reset asserted mid-transfer aborts the transfer; no strobe is issued after reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1]. IDLE and BUSY transfers give a zero-wait OKAY.
- Illegal access (any one of):
  - offset >= ADDR_RANGE;
  - HADDR not aligned to HSIZE;
  - 2^HSIZE > DATA_WID/8.
- Illegal-access response: ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. No csr strobe is issued.
- Write path:
  - Data phase is zero-wait (HREADYOUT stays 1).
  - Address, size and offset are latched in the address phase.
  - At the end of the data phase, csr_wdata is captured from HWDATA.
  - csr_wren pulses in the cycle after the data phase; csr_wstrb is set in that same cycle.
  - csr_wstrb is little-endian: 2^HSIZE contiguous ones starting at lane HADDR[log2(DATA_WID/8)-1:0].
- Read path:
  - State RWAIT, HREADYOUT=0.
  - csr_rden pulses in the first data-phase cycle, with csr_addr valid.
  - Exception: if a posted write issues in that same cycle, csr_wren goes first and csr_rden is delayed by one cycle. Read-after-write ordering is therefore guaranteed.
  - On csr_rvalid, HRDATA <= csr_rdata. HREADYOUT=1 with HRESP=0 in the next cycle, then IDLE.
- Minimum read data phase: 3 cycles.
- HRDATA holds its last read value; it is not cleared by writes.
- csr_rvalid outside RWAIT is ignored.
- Back-to-back writes sustain one write per cycle. A new address phase is accepted during a write data phase.
- States: IDLE, RWAIT, ERR1, ERR2. A pending-write flag operates in parallel with these states.
- A transfer is never accepted while HREADYOUT=0.

Optional Feature:
- Macro: AHB_CSR_TIMEOUT_EN.
- Defined:
  - A counter starts at csr_rden.
  - If csr_rvalid has not arrived after TIMEOUT_CYCLES cycles, the bridge goes through ERR1/ERR2 (ERROR response) and HRDATA = all-ones.
  - A late csr_rvalid is ignored.
- Undefined: RWAIT waits indefinitely; no counter logic is synthesised.

Test Plan:
- Reset: hold HRESET for 3 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0, csr_wren=csr_rden=0.
- Word write 0x010 = 0xCAFEF00D, DATA_WID=32 -> zero-wait data phase; the next cycle has csr_wren=1, csr_addr=0x010, csr_wstrb=4'b1111, csr_wdata=0xCAFEF00D.
- Byte write 0x013 (HSIZE=0) followed immediately by a read of 0x010, with csr_rvalid returned 2 cycles after csr_rden carrying 0x12345678:
  - write: csr_wstrb=4'b1000;
  - ordering: csr_rden occurs one cycle after csr_wren;
  - response: HRDATA=0x12345678, OKAY.
- Misaligned halfword at 0x011, and a write to 0x1000 with ADDR_RANGE=4096 -> each gets two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1); no csr strobes.
- Four back-to-back NONSEQ writes to 0x0,0x4,0x8,0xC -> HREADYOUT constantly 1; four consecutive csr_wren pulses in address order.
- With AHB_CSR_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with csr_rvalid never asserted -> ERROR response after 8 cycles, HRDATA=0xFFFFFFFF; a later csr_rvalid is ignored.

Source files
------------

// File: rtl/ahb_csr_bridge.sv
// ahb_csr_bridge
// AHB-Lite slave that bridges single-beat AHB transfers onto a simple CSR bus.
// One instance sits behind the AHB decoder for each CSR bank.
//
// Features:
//   - Writes are posted with zero wait states.
//   - Byte strobes are derived from HSIZE and HADDR.
//   - Reads have variable latency and complete on a csr_rvalid handshake.
//   - Illegal accesses get a two-cycle ERROR response.
//
// Optional feature (macro AHB_CSR_TIMEOUT_EN):
//   When defined, a read that sees no csr_rvalid within TIMEOUT_CYCLES cycles
//   of csr_rden ends with an ERROR response, and HRDATA reads as all-ones.
//
// Ports:
//   HCLK, HRESET           clock; asynchronous active-high reset
//   HSEL .. HWDATA         AHB-Lite slave inputs
//   HREADYOUT, HRESP       AHB-Lite slave response
//   HRDATA                 read data; holds the last completed read
//   csr_addr               CSR byte address, aligned to DATA_WID
//   csr_wren/wstrb/wdata   one-cycle write pulse with byte strobes and data
//   csr_rden               one-cycle read pulse
//   csr_rdata/csr_rvalid   read data return from the CSR bank
module ahb_csr_bridge #(
   parameter int unsigned ADDR_WID       = 12,
   parameter int unsigned DATA_WID       = 32,
   parameter int unsigned ADDR_RANGE     = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [DATA_WID-1:0]   HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WID-1:0]   HRDATA,
   output logic [ADDR_WID-1:0]   csr_addr,
   output logic                  csr_wren,
   output logic [DATA_WID/8-1:0] csr_wstrb,
   output logic [DATA_WID-1:0]   csr_wdata,
   output logic                  csr_rden,
   input  logic [DATA_WID-1:0]   csr_rdata,
   input  logic                  csr_rvalid
);

   localparam int unsigned NB = DATA_WID / 8;
   localparam int unsigned LB = $clog2(NB);

   typedef enum logic [1:0] {StIdle, StRwait, StErr1, StErr2} state_t;

   state_t                state_q, state_d;
   logic                  wr_dphase_q, wr_dphase_d;
   logic [ADDR_WID-1:0]   wr_addr_q, wr_addr_d;
   logic [NB-1:0]         wr_strb_q, wr_strb_d;
   logic [ADDR_WID-1:0]   rd_addr_q, rd_addr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  wren_q, wren_d;
   logic                  rden_q, rden_d;
   logic [ADDR_WID-1:0]   addr_q, addr_d;
   logic [NB-1:0]         wstrb_q, wstrb_d;
   logic [DATA_WID-1:0]   wdata_q, wdata_d;
   logic [DATA_WID-1:0]   hrdata_q, hrdata_d;

`ifdef AHB_CSR_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
`endif

   logic                  accept;
   logic                  illegal;
   logic [31:0]           size_bytes;
   logic [31:0]           lane;
   logic [NB-1:0]         strb_a;
   logic [ADDR_WID-1:0]   addr_a;
   logic                  unused_htrans;

   assign unused_htrans = HTRANS[0];

   assign HREADYOUT = !(state_q == StRwait || state_q == StErr1);
   assign HRESP     = (state_q == StErr1 || state_q == StErr2);

   // Gating with HREADYOUT keeps a stalled slave from taking a new transfer.
   assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

   // HADDR is treated as the byte offset into this bank.
   always_comb begin
      size_bytes = 32'd1 << HSIZE;
      lane       = 32'(HADDR[LB-1:0]);
      illegal    = (HADDR >= ADDR_RANGE) ||
                   ((HADDR & (size_bytes - 32'd1)) != 32'd0) ||
                   (size_bytes > NB);
      for (int unsigned i = 0; i < NB; i++) begin
         strb_a[i] = (i >= lane) && (i < lane + size_bytes);
      end
      addr_a = {HADDR[ADDR_WID-1:LB], {LB{1'b0}}};
   end

   always_comb begin
      state_d     = state_q;
      wr_dphase_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_strb_d   = wr_strb_q;
      rd_addr_d   = rd_addr_q;
      rd_pend_d   = 1'b0;
      wren_d      = 1'b0;
      rden_d      = 1'b0;
      addr_d      = addr_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      hrdata_d    = hrdata_q;
`ifdef AHB_CSR_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      // Posted write: issue in the cycle after its data phase.
      if (wr_dphase_q) begin
         wren_d  = 1'b1;
         addr_d  = wr_addr_q;
         wstrb_d = wr_strb_q;
         wdata_d = HWDATA;
      end

      // Read that was pushed back one cycle behind a posted write.
      if (rd_pend_q) begin
         rden_d = 1'b1;
         addr_d = rd_addr_q;
      end

      unique case (state_q)
         StIdle, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               if (illegal) begin
                  state_d = StErr1;
               end else if (HWRITE) begin
                  wr_dphase_d = 1'b1;
                  wr_addr_d   = addr_a;
                  wr_strb_d   = strb_a;
               end else begin
                  state_d   = StRwait;
                  rd_addr_d = addr_a;
                  // A write issuing in our first data-phase cycle goes first.
                  if (wr_dphase_q) begin
                     rd_pend_d = 1'b1;
                  end else begin
                     rden_d = 1'b1;
                     addr_d = addr_a;
                  end
               end
            end
         end
         StRwait: begin
            // csr_rvalid is only honoured once the read strobe has gone out.
            if (rden_q || rd_pend_q) begin
`ifdef AHB_CSR_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end else if (csr_rvalid) begin
               hrdata_d = csr_rdata;
               state_d  = StIdle;
            end
`ifdef AHB_CSR_TIMEOUT_EN
            else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               hrdata_d = '1;
               state_d  = StErr1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
`endif
         end
         StErr1: begin
            state_d = StErr2;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= StIdle;
         wr_dphase_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_strb_q   <= '0;
         rd_addr_q   <= '0;
         rd_pend_q   <= 1'b0;
         wren_q      <= 1'b0;
         rden_q      <= 1'b0;
         addr_q      <= '0;
         wstrb_q     <= '0;
         wdata_q     <= '0;
         hrdata_q    <= '0;
`ifdef AHB_CSR_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_dphase_q <= wr_dphase_d;
         wr_addr_q   <= wr_addr_d;
         wr_strb_q   <= wr_strb_d;
         rd_addr_q   <= rd_addr_d;
         rd_pend_q   <= rd_pend_d;
         wren_q      <= wren_d;
         rden_q      <= rden_d;
         addr_q      <= addr_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         hrdata_q    <= hrdata_d;
`ifdef AHB_CSR_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign HRDATA    = hrdata_q;
   assign csr_addr  = addr_q;
   assign csr_wren  = wren_q;
   assign csr_wstrb = wstrb_q;
   assign csr_wdata = wdata_q;
   assign csr_rden  = rden_q;

endmodule

// File: tb/tb_ahb_csr_bridge.sv
// Testbench for ahb_csr_bridge (DATA_WID=32, ADDR_WID=12, ADDR_RANGE=4096).
// A byte-array reference model predicts responses, strobes and read data.
// A CSR bank model answers csr_rden after a programmable latency.
module tb_ahb_csr_bridge;

   localparam int TMO      = 8;
   localparam int WAIT_MAX = 200;

   logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA, csr_wdata, csr_rdata;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [11:0] csr_addr;
   logic        csr_wren, csr_rden, csr_rvalid;
   logic [3:0]  csr_wstrb;

   ahb_csr_bridge #(
      .ADDR_WID(12), .DATA_WID(32), .ADDR_RANGE(4096), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .csr_addr(csr_addr),
      .csr_wren(csr_wren), .csr_wstrb(csr_wstrb), .csr_wdata(csr_wdata),
      .csr_rden(csr_rden), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid)
   );

   // Single-slave bus: the interconnect returns our own HREADYOUT as HREADY.
   assign HREADY = HREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   typedef struct {
      bit          idle;
      bit          wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          err;
      bit          tmo;
      logic [3:0]  strb;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   xfer_t       xq[$];
   ev_t         exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$];
   logic [7:0]  ref_mem[4096];
   logic [31:0] dev_mem[1024];
   logic [31:0] last_rd = 32'h0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rv_lat  = 0;
   bit          tmo_mode = 0;
   bit          spur = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: applies each AHB transfer to a byte array in program order.
   function automatic void add(input bit idle, input bit wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
      xfer_t t;
      int    nbytes;
      int    ln;
      nbytes  = 1 << size;
      t.idle  = idle;
      t.wr    = wr;
      t.size  = size;
      t.addr  = addr;
      t.wdata = wdata;
      t.strb  = 4'b0;
      t.rdata = 32'h0;
      t.tmo   = 1'b0;
      t.err   = !idle && (addr >= 4096 || (addr % nbytes) != 0 || nbytes > 4);
      if (!idle && !t.err) begin
         if (wr) begin
            for (int b = 0; b < nbytes; b++) begin
               ln = (addr + b) % 4;
               ref_mem[addr + b] = wdata[8*ln +: 8];
               t.strb[ln] = 1'b1;
            end
         end else if (tmo_mode) begin
            t.tmo   = 1'b1;
            t.rdata = 32'hFFFF_FFFF;
         end else begin
            for (int b = 0; b < 4; b++) t.rdata[8*b +: 8] = ref_mem[(addr / 4) * 4 + b];
         end
      end
      xq.push_back(t);
   endfunction

   task automatic complete(input xfer_t t, input int waited, input bit first_resp);
      if (t.idle) begin
         chk("idle_wait", waited, 0);
         chk("idle_resp", HRESP, 0);
      end else if (t.err) begin
         chk("err_wait", waited, 1);
         chk("err_resp_first", first_resp, 1);
         chk("err_resp_last", HRESP, 1);
      end else if (t.wr) begin
         chk("wr_wait", waited, 0);
         chk("wr_resp", HRESP, 0);
         exp_wr.push_back('{addr: (t.addr / 4) * 4, strb: t.strb, data: t.wdata, cyc: cyc + 1});
      end else if (t.tmo) begin
         chk("tmo_resp", HRESP, 1);
         chk("tmo_hrdata", HRDATA, t.rdata);
         last_rd = t.rdata;
      end else begin
         chk("rd_resp", HRESP, 0);
         chk("rd_hrdata", HRDATA, t.rdata);
         chk("rd_min_phase", 64'(waited >= 2), 1);
         last_rd = t.rdata;
      end
   endtask

   // Pipelined AHB master: drives xq back to back; enter and leave at posedge+1.
   task automatic run();
      int    ia = 0;
      bit    dv = 0;
      xfer_t dp;
      xfer_t na;
      int    waited = 0;
      bit    first_resp = 0;
      bit    wr_issue;
      while (ia < xq.size() || dv) begin
         if (ia < xq.size()) begin
            na     = xq[ia];
            HSEL   = 1'b1;
            HADDR  = na.addr;
            HWRITE = na.wr;
            HSIZE  = na.size;
            HTRANS = na.idle ? 2'($urandom_range(0, 1)) : 2'b10;
         end else begin
            HSEL   = 1'b0;
            HTRANS = 2'b00;
            HWRITE = 1'b0;
         end
         HWDATA = (dv && dp.wr && !dp.idle) ? dp.wdata : $urandom;
         @(negedge HCLK);
         if (!HREADYOUT) begin
            if (dv && waited == 0) first_resp = HRESP;
            waited++;
            if (waited > WAIT_MAX) begin
               n_tests++;
               n_fail++;
               $error("FAIL wait_bound: observed %0d stall cycles, required at most %0d",
                      waited, WAIT_MAX);
               xq.delete();
               @(posedge HCLK);
               #1;
               return;
            end
         end else begin
            wr_issue = dv && !dp.idle && dp.wr && !dp.err;
            if (dv) complete(dp, waited, first_resp);
            dv = 1'b0;
            if (ia < xq.size()) begin
               na = xq[ia];
               if (!na.idle && !na.wr && !na.err)
                  exp_rd.push_back('{addr: (na.addr / 4) * 4, strb: 4'b0, data: 32'h0,
                                     cyc: cyc + 1 + (wr_issue ? 1 : 0)});
               dp         = na;
               dv         = 1'b1;
               waited     = 0;
               first_resp = 1'b0;
               ia++;
            end
         end
         @(posedge HCLK);
         #1;
      end
      xq.delete();
   endtask

   // CSR bank model and strobe monitor.
   initial begin
      bit          rd_pend = 0;
      int          rd_cnt  = 0;
      logic [9:0]  rd_word = '0;
      csr_rvalid = 1'b0;
      csr_rdata  = 32'h0;
      forever begin
         @(negedge HCLK);
         csr_rvalid = 1'b0;
         csr_rdata  = $urandom;
         if (csr_wren) begin
            obs_wr.push_back('{addr: 32'(csr_addr), strb: csr_wstrb, data: csr_wdata, cyc: cyc});
            for (int b = 0; b < 4; b++)
               if (csr_wstrb[b]) dev_mem[csr_addr[11:2]][8*b +: 8] = csr_wdata[8*b +: 8];
         end
         if (csr_rden) obs_rd.push_back('{addr: 32'(csr_addr), strb: 4'b0, data: 32'h0, cyc: cyc});
         if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               csr_rvalid = 1'b1;
               csr_rdata  = dev_mem[rd_word];
               rd_pend    = 1'b0;
            end
         end
         if (csr_rden) begin
            rd_pend = 1'b1;
            rd_cnt  = (rv_lat != 0) ? rv_lat : int'($urandom_range(1, 3));
            rd_word = csr_addr[11:2];
         end
         if (spur) begin
            csr_rvalid = 1'b1;
            spur       = 1'b0;
         end
      end
   end

   initial begin
      int          nw;
      int          n;
      int          k;
      logic [2:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 11);
      for (int w = 0; w < 1024; w++)
         for (int b = 0; b < 4; b++) dev_mem[w][8*b +: 8] = 8'((4 * w + b) * 37 + 11);
      HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2;
      HTRANS = 2'b00; HWDATA = 32'h0;

      // Reset held for three cycles.
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_hreadyout", HREADYOUT, 1);
      chk("rst_hresp", HRESP, 0);
      chk("rst_hrdata", HRDATA, 0);
      chk("rst_wren", csr_wren, 0);
      chk("rst_rden", csr_rden, 0);
      chk("rst_wstrb", csr_wstrb, 0);
      chk("rst_addr", csr_addr, 0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      // Word write.
      add(0, 1, 3'd2, 32'h010, 32'hCAFE_F00D);
      run();

      // Byte write followed at once by a read of the same word.
      add(0, 1, 3'd2, 32'h010, 32'hAA34_5678);
      add(0, 1, 3'd0, 32'h013, 32'h12FF_EEDD);
      add(0, 0, 3'd2, 32'h010, 32'h0);
      rv_lat = 2;
      run();
      rv_lat = 0;

      // Stray csr_rvalid while idle must not disturb HRDATA.
      spur = 1'b1;
      @(posedge HCLK);
      #1;
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      chk("spur_hrdata", HRDATA, last_rd);
      @(posedge HCLK);
      #1;

      // Illegal accesses: misaligned, out of range, oversize.
      add(0, 1, 3'd1, 32'h011, 32'h1111_2222);
      add(0, 1, 3'd2, 32'h1000, 32'h3333_4444);
      add(0, 0, 3'd3, 32'h008, 32'h0);
      add(0, 0, 3'd2, 32'hFFFC, 32'h0);
      run();

      // Back-to-back writes, then read back.
      add(0, 1, 3'd2, 32'h000, 32'h0101_0101);
      add(0, 1, 3'd2, 32'h004, 32'h0202_0202);
      add(0, 1, 3'd2, 32'h008, 32'h0303_0303);
      add(0, 1, 3'd2, 32'h00C, 32'h0404_0404);
      add(0, 0, 3'd2, 32'h000, 32'h0);
      add(0, 0, 3'd2, 32'h00C, 32'h0);
      run();

      // Reset during a write data phase aborts the write.
      nw     = obs_wr.size();
      HSEL   = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h020;
      @(negedge HCLK);
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
      #2 HRESET = 1'b1;
      @(posedge HCLK);
      #1;
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rst_abort_wren", obs_wr.size(), nw);
      chk("rst_abort_hreadyout", HREADYOUT, 1);
      chk("rst_abort_hrdata", HRDATA, 0);
      last_rd = 32'h0;
      @(posedge HCLK);
      #1;

      // Randomised mix.
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 19);
         if (k == 0) begin
            add(1, 0, 3'd0, $urandom, 32'h0);
         end else begin
            sz = (k == 1) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = (k == 2) ? 32'($urandom_range(4090, 4200)) : 32'($urandom_range(0, 63));
            if (k > 4) a = a & ~((32'd1 << sz) - 32'd1);
            add(0, 1'($urandom_range(0, 1)), sz, a, $urandom);
         end
      end
      run();

`ifdef AHB_CSR_TIMEOUT_EN
      // Read with no timely csr_rvalid; the late one that follows is ignored.
      tmo_mode = 1'b1;
      rv_lat   = TMO + 6;
      add(0, 0, 3'd2, 32'h010, 32'h0);
      run();
      tmo_mode = 1'b0;
      repeat (TMO + 10) @(posedge HCLK);
      #1;
      @(negedge HCLK);
      chk("tmo_late_hrdata", HRDATA, 32'hFFFF_FFFF);
      chk("tmo_late_hreadyout", HREADYOUT, 1);
      chk("tmo_late_hresp", HRESP, 0);
      @(posedge HCLK);
      #1;
      rv_lat = 0;
      add(0, 0, 3'd2, 32'h014, 32'h0);
      run();
`endif

      repeat (6) @(posedge HCLK);
      #1;
      @(negedge HCLK);

      // Strobe streams against the model's predictions.
      chk("wr_count", obs_wr.size(), exp_wr.size());
      n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("wr%0d_addr", i), obs_wr[i].addr, exp_wr[i].addr);
         chk($sformatf("wr%0d_strb", i), obs_wr[i].strb, exp_wr[i].strb);
         chk($sformatf("wr%0d_data", i), obs_wr[i].data, exp_wr[i].data);
         chk($sformatf("wr%0d_cyc", i), obs_wr[i].cyc, exp_wr[i].cyc);
      end
      chk("rd_count", obs_rd.size(), exp_rd.size());
      n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("rd%0d_addr", i), obs_rd[i].addr, exp_rd[i].addr);
         chk($sformatf("rd%0d_cyc", i), obs_rd[i].cyc, exp_rd[i].cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
